// File: rtl/mem_stage.sv
// RV32I memory-access stage: serialises loads and stores onto a byte-wide synchronous
// RAM port while stalling the pipeline, and drives the writeback bus.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        modify_flag,
    input  logic [4:0]  modify_address,
    input  logic [31:0] modify_data,
    input  logic        load,
    input  logic        save,
    input  logic [31:0] sl_addr,
    input  logic [31:0] sl_data,
    input  logic [2:0]  sl_data_length,
    input  logic        sl_data_signed,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        stall_req,
    output logic        wb_flag,
    output logic [4:0]  wb_address,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [2:0]  cnt_r;
    logic [31:0] buf_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic [2:0]  len_r;
    logic        signed_r;
    logic        is_load_r;
    logic        start_s;
    logic        issue_s;

    logic [31:0] mem_addr_s;
    logic [7:0]  mem_wdata_s;
    logic        mem_we_s;
    logic        stall_s;
    logic        wb_flag_s;
    logic [4:0]  wb_address_s;
    logic [31:0] wb_data_s;

    function automatic logic [2:0] norm_len(input logic [2:0] code);
        logic [2:0] len_v;
        case (code)
            3'd1:    len_v = 3'd1;
            3'd2:    len_v = 3'd2;
            default: len_v = 3'd4;
        endcase
        return len_v;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [2:0] idx);
        logic [7:0] byte_v;
        case (idx[1:0])
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        return byte_v;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] len,
                                           input logic sgn);
        logic [31:0] ext_v;
        case (len)
            3'd1:    ext_v = {{24{sgn & raw[7]}}, raw[7:0]};
            3'd2:    ext_v = {{16{sgn & raw[15]}}, raw[15:0]};
            default: ext_v = raw;
        endcase
        return ext_v;
    endfunction

    assign start_s = (state_r == ST_IDLE) && (load || save);
    assign issue_s = (cnt_r < len_r);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == len_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operation latches, byte counter and load assembly buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= 3'd0;
            buf_r     <= 32'd0;
            addr_r    <= 32'd0;
            data_r    <= 32'd0;
            len_r     <= 3'd0;
            signed_r  <= 1'b0;
            is_load_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        addr_r    <= sl_addr;
                        data_r    <= sl_data;
                        len_r     <= norm_len(sl_data_length);
                        signed_r  <= sl_data_signed;
                        is_load_r <= load;
                        cnt_r     <= 3'd1;
                        buf_r     <= 32'd0;
                    end else begin
                        cnt_r <= 3'd0;
                    end
                end
                ST_ACCESS: begin
                    // The byte addressed last cycle is on mem_rdata now.
                    if (is_load_r) begin
                        case (cnt_r)
                            3'd1:    buf_r[7:0]   <= mem_rdata;
                            3'd2:    buf_r[15:8]  <= mem_rdata;
                            3'd3:    buf_r[23:16] <= mem_rdata;
                            3'd4:    buf_r[31:24] <= mem_rdata;
                            default: buf_r        <= buf_r;
                        endcase
                    end else begin
                        buf_r <= buf_r;
                    end
                    cnt_r <= cnt_r + 3'd1;
                end
                ST_DONE: cnt_r <= 3'd0;
                default: cnt_r <= 3'd0;
            endcase
        end
    end

    // Output decode; everything is forced to zero while reset is asserted.
    always_comb begin
        mem_addr_s   = 32'd0;
        mem_wdata_s  = 8'd0;
        mem_we_s     = 1'b0;
        stall_s      = 1'b0;
        wb_flag_s    = 1'b0;
        wb_address_s = 5'd0;
        wb_data_s    = 32'd0;
        if (!rst) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        mem_addr_s = sl_addr;
                        stall_s    = 1'b1;
                        if (!load) begin
                            mem_we_s    = 1'b1;
                            mem_wdata_s = sl_data[7:0];
                        end else begin
                            mem_we_s = 1'b0;
                        end
                    end else begin
                        wb_flag_s    = modify_flag;
                        wb_address_s = modify_address;
                        wb_data_s    = modify_data;
                    end
                end
                ST_ACCESS: begin
                    stall_s = 1'b1;
                    if (issue_s) begin
                        mem_addr_s = addr_r + {29'd0, cnt_r};
                        if (!is_load_r) begin
                            mem_we_s    = 1'b1;
                            mem_wdata_s = byte_of(data_r, cnt_r);
                        end else begin
                            mem_we_s = 1'b0;
                        end
                    end else begin
                        mem_addr_s = 32'd0;
                    end
                end
                ST_DONE: begin
                    if (is_load_r) begin
                        wb_flag_s    = modify_flag;
                        wb_address_s = modify_address;
                        wb_data_s    = extend(buf_r, len_r, signed_r);
                    end else begin
                        wb_flag_s = 1'b0;
                    end
                end
                default: stall_s = 1'b0;
            endcase
        end
    end

    assign mem_addr   = mem_addr_s;
    assign mem_wdata  = mem_wdata_s;
    assign mem_we     = mem_we_s;
    assign stall_req  = stall_s;
    assign wb_flag    = wb_flag_s;
    assign wb_address = wb_address_s;
    assign wb_data    = wb_data_s;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a 256-byte synchronous RAM, a transaction-level
// reference memory, and one negedge compare process against per-cycle expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        modify_flag;
    logic [4:0]  modify_address;
    logic [31:0] modify_data;
    logic        load;
    logic        save;
    logic [31:0] sl_addr;
    logic [31:0] sl_data;
    logic [2:0]  sl_data_length;
    logic        sl_data_signed;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        stall_req;
    logic        wb_flag;
    logic [4:0]  wb_address;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .modify_flag(modify_flag), .modify_address(modify_address), .modify_data(modify_data),
        .load(load), .save(save), .sl_addr(sl_addr), .sl_data(sl_data),
        .sl_data_length(sl_data_length), .sl_data_signed(sl_data_signed),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .stall_req(stall_req), .wb_flag(wb_flag), .wb_address(wb_address), .wb_data(wb_data)
    );

    // RAM aliased on the low address byte; the reference memory mirrors that aliasing.
    logic [7:0] ram [256];
    logic [7:0] ref_mem [256];
    logic       init_req;
    logic [7:0] seed;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 73 + int'(seed)) & 255);
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
        end else if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr[7:0]];
    end

    logic        chk_en;
    logic        e_stall, e_we, e_chk_wdata, e_chk_addr, e_wb_flag, e_chk_wb;
    logic [7:0]  e_wdata;
    logic [31:0] e_addr, e_wb_data;
    logic [4:0]  e_wb_addr;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_req", 32'(stall_req), 32'(e_stall));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("wb_flag", 32'(wb_flag), 32'(e_wb_flag));
            if (e_chk_wdata) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            if (e_chk_addr) chk("mem_addr", mem_addr, e_addr);
            if (e_chk_wb) begin
                chk("wb_address", 32'(wb_address), 32'(e_wb_addr));
                chk("wb_data", wb_data, e_wb_data);
            end
        end
    end

    task automatic expect_zero();
        e_stall = 1'b0; e_we = 1'b0; e_wb_flag = 1'b0;
        e_wdata = 8'd0; e_addr = 32'd0; e_wb_addr = 5'd0; e_wb_data = 32'd0;
        e_chk_wdata = 1'b1; e_chk_addr = 1'b1; e_chk_wb = 1'b1;
    endtask

    // One EX/MEM op held on the inputs until it completes; abort_at>=0 pulls reset in that cycle.
    task automatic run_op(input logic ld, input logic st, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] lc, input logic sg,
                          input logic mf, input logic [4:0] ma, input logic [31:0] md,
                          input int abort_at, input logic use_lit, input logic [31:0] lit);
        int          n;
        longint      v;
        logic [31:0] exp_wb;
        load = ld; save = st; sl_addr = a; sl_data = d; sl_data_length = lc;
        sl_data_signed = sg; modify_flag = mf; modify_address = ma; modify_data = md;
        if (!ld && !st) begin
            expect_zero();
            e_chk_wdata = 1'b0;
            e_wb_flag = mf; e_wb_addr = ma; e_wb_data = md;
            @(posedge clk); #1;
            return;
        end
        n = (lc == 3'd1) ? 1 : ((lc == 3'd2) ? 2 : 4);
        v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[8'(a + 32'(i))]);
        if (sg && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        exp_wb = use_lit ? lit : 32'(v);
        for (int k = 0; k <= n + 1; k++) begin
            if (k == abort_at) begin
                rst = 1'b0;
                expect_zero();
                @(posedge clk); #1;
                rst = 1'b1; load = 1'b0; save = 1'b0; modify_flag = 1'b0;
                expect_zero();
                e_chk_wdata = 1'b0;
                e_wb_addr = ma; e_wb_data = md;
                return;
            end
            if (k <= n) begin
                e_stall = 1'b1; e_we = !ld && (k < n); e_chk_wdata = e_we;
                e_wdata = 8'(d >> (8 * k)); e_chk_addr = (k < n); e_addr = a + 32'(k);
                e_wb_flag = 1'b0; e_chk_wb = 1'b0;
            end else begin
                e_stall = 1'b0; e_we = 1'b0; e_chk_wdata = 1'b0; e_chk_addr = 1'b0;
                e_wb_flag = ld ? mf : 1'b0; e_chk_wb = ld; e_wb_addr = ma; e_wb_data = exp_wb;
            end
            @(posedge clk); #1;
            if (!ld && k < n) ref_mem[8'(a + 32'(k))] = 8'(d >> (8 * k));
        end
    endtask

    initial begin
        int          kind;
        int          abort_at;
        logic        ld, st;
        logic [31:0] a;
        seed = 8'($urandom);
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        chk_en = 1'b0; init_req = 1'b1; rst = 1'b0;
        load = 1'b1; save = 1'b1; modify_flag = 1'b1; modify_address = 5'd3;
        modify_data = 32'hFFFF_FFFF; sl_addr = 32'h0000_0100; sl_data = 32'h1234_5678;
        sl_data_length = 3'd4; sl_data_signed = 1'b1;
        expect_zero();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0; rst = 1'b1;

        run_op(1'b0, 1'b0, 32'd0, 32'd0, 3'd4, 1'b0, 1'b1, 5'd5, 32'h1234_5678, -1, 1'b0, 32'd0);
        run_op(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'd4, 1'b0, 1'b0, 5'd0, 32'd0, -1, 1'b0, 32'd0);
        run_op(1'b1, 1'b0, 32'h103, 32'd0, 3'd1, 1'b1, 1'b1, 5'd7, 32'd0, -1, 1'b1, 32'hFFFF_FFDE);
        run_op(1'b1, 1'b0, 32'h103, 32'd0, 3'd1, 1'b0, 1'b1, 5'd7, 32'd0, -1, 1'b1, 32'h0000_00DE);
        run_op(1'b1, 1'b0, 32'h102, 32'd0, 3'd2, 1'b1, 1'b1, 5'd9, 32'd0, -1, 1'b1, 32'hFFFF_DEAD);
        run_op(1'b1, 1'b0, 32'h102, 32'd0, 3'd2, 1'b0, 1'b1, 5'd9, 32'd0, -1, 1'b1, 32'h0000_DEAD);
        run_op(1'b1, 1'b1, 32'h100, 32'd0, 3'd4, 1'b1, 1'b1, 5'd1, 32'd0, -1, 1'b1, 32'hDEAD_BEEF);
        run_op(1'b0, 1'b1, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 3'd4, 1'b0, 1'b0, 5'd0, 32'd0, -1, 1'b0, 32'd0);
        run_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd0, 3'd4, 1'b0, 1'b1, 5'd2, 32'd0, -1, 1'b1, 32'hA1B2_C3D4);
        run_op(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 3'd4, 1'b0, 1'b0, 5'd0, 32'd0, 2, 1'b0, 32'd0);
        run_op(1'b1, 1'b0, 32'h40, 32'd0, 3'd4, 1'b0, 1'b1, 5'd4, 32'd0, -1, 1'b0, 32'd0);

        for (int t = 0; t < 250; t++) begin
            kind = int'($urandom_range(0, 9));
            ld = (kind >= 3 && kind <= 5) || kind == 9;
            st = (kind >= 6);
            a = ($urandom_range(0, 3) == 0) ? $urandom : (32'h100 + $urandom_range(0, 15));
            abort_at = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_op(ld, st, a, $urandom, 3'($urandom_range(0, 7)), 1'($urandom),
                   1'($urandom), 5'($urandom), $urandom, abort_at, 1'b0, 32'd0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
